// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: checks the one-hot light bus for encoding, sequence and dwell faults, and counts light cycles.
// Define TLM_DWELL_CHECK_EN to enable dwell-time checking (fault codes 3 and 4).
module traffic_light_monitor #(
  parameter int DW        = 8,
  parameter int RED_DWELL = 31,
  parameter int YEL_DWELL = 11,
  parameter int GRN_DWELL = 41
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    light_in,
  input  logic          clr_fault,
  output logic          fault,
  output logic [2:0]    fault_code,
  output logic [DW-1:0] cur_dwell,
  output logic [15:0]   cycle_cnt,
  output logic          cycle_done,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_RED = 2'd1,
    S_YEL = 2'd2,
    S_GRN = 2'd3
  } state_t;

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_ENC   = 3'd1;
  localparam logic [2:0] C_TRANS = 3'd2;
  localparam logic [2:0] C_SHORT = 3'd3;
  localparam logic [2:0] C_LONG  = 3'd4;

  // Dwell limits must fit in the dwell counter.
  if (RED_DWELL >= (2 ** DW) || YEL_DWELL >= (2 ** DW) || GRN_DWELL >= (2 ** DW)) begin : g_bad_dwell
    $error("traffic_light_monitor: a dwell limit does not fit in DW bits");
  end

  state_t        state, state_nx, samp, succ;
  logic          samp_ok, same, legal;
  logic          short_dwell, long_dwell, cyc;
  logic [DW-1:0] dwell_nx;
  logic [2:0]    code;

  always_comb begin
    samp    = S_OFF;
    samp_ok = 1'b1;
    case (light_in)
      3'b000:  samp = S_OFF;
      3'b001:  samp = S_RED;
      3'b010:  samp = S_YEL;
      3'b100:  samp = S_GRN;
      default: samp_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (state)
      S_OFF:   succ = S_RED;
      S_RED:   succ = S_YEL;
      S_YEL:   succ = S_GRN;
      default: succ = S_RED;
    endcase
  end

  assign same  = samp_ok && (samp == state);
  assign legal = (samp == S_OFF) || (samp == succ);

`ifdef TLM_DWELL_CHECK_EN
  logic [DW-1:0] req_dwell;
  logic          long_seen, long_seen_nx;

  always_comb begin
    case (state)
      S_RED:   req_dwell = DW'(RED_DWELL);
      S_YEL:   req_dwell = DW'(YEL_DWELL);
      S_GRN:   req_dwell = DW'(GRN_DWELL);
      default: req_dwell = '0;
    endcase
  end

  // long_seen keeps code 4 to one report per dwell episode, even when the counter saturates.
  always_comb begin
    long_dwell   = 1'b0;
    short_dwell  = 1'b0;
    long_seen_nx = long_seen;
    if (samp_ok) begin
      if (same) begin
        if (state != S_OFF && cur_dwell == req_dwell && !long_seen) begin
          long_dwell   = 1'b1;
          long_seen_nx = 1'b1;
        end
      end else begin
        long_seen_nx = 1'b0;
        short_dwell  = legal && (samp != S_OFF) && (state != S_OFF) && (cur_dwell < req_dwell);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) long_seen <= 1'b0;
    else      long_seen <= long_seen_nx;
  end
`else
  assign short_dwell = 1'b0;
  assign long_dwell  = 1'b0;
`endif

  // Code priority 1 > 2 > 3 > 4 falls out of the branch structure.
  always_comb begin
    state_nx = state;
    dwell_nx = cur_dwell;
    code     = C_NONE;
    cyc      = 1'b0;
    if (!samp_ok) begin
      code = C_ENC;
    end else if (same) begin
      if (cur_dwell != '1) dwell_nx = cur_dwell + DW'(1);
      if (long_dwell) code = C_LONG;
    end else begin
      state_nx = samp;
      dwell_nx = DW'(1);
      if (!legal)                              code = C_TRANS;
      else if (short_dwell)                    code = C_SHORT;
      else if (state == S_GRN && samp == S_RED) cyc = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_OFF;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault      <= 1'b0;
      fault_code <= C_NONE;
      cur_dwell  <= '0;
      cycle_cnt  <= '0;
      cycle_done <= 1'b0;
    end else begin
      cur_dwell  <= dwell_nx;
      cycle_done <= cyc;
      if (cyc && cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 16'd1;
      // A fresh fault on the clearing edge takes precedence over the clear.
      if (code != C_NONE && (!fault || clr_fault)) begin
        fault      <= 1'b1;
        fault_code <= code;
      end else if (clr_fault) begin
        fault      <= 1'b0;
        fault_code <= C_NONE;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: segment table, hand sequences for reset/saturation, and a random run
// checked every cycle against a colour/counter reference model.
module tb_traffic_light_monitor;

`ifdef TLM_DWELL_CHECK_EN
  localparam bit DE = 1'b1;
`else
  localparam bit DE = 1'b0;
`endif
  localparam int         DMAX = 255;
  localparam logic [2:0] OFF  = 3'b000;
  localparam logic [2:0] RED  = 3'b001;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  light_in = 3'b000;
  logic        clr_fault = 1'b0;
  logic        fault;
  logic [2:0]  fault_code;
  logic [7:0]  cur_dwell;
  logic [15:0] cycle_cnt;
  logic        cycle_done;
  logic [1:0]  dbg_state;

  traffic_light_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .light_in   (light_in),
    .clr_fault  (clr_fault),
    .fault      (fault),
    .fault_code (fault_code),
    .cur_dwell  (cur_dwell),
    .cycle_cnt  (cycle_cnt),
    .cycle_done (cycle_done),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [30:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: colour index 0 OFF,1 RED,2 YELLOW,3 GREEN; the legal successor of c is (c%3)+1.
  int m_col, m_dwell, m_code, m_cnt;
  bit m_fault, m_done, m_long_seen;
  int req_tab[4] = '{0, 31, 11, 41};

  function automatic int colour_of(input logic [2:0] l);
    if ($countones(l) > 1) return -1;
    if (l == 3'b000) return 0;
    if (l[0]) return 1;
    if (l[1]) return 2;
    return 3;
  endfunction

  function automatic logic [2:0] light_of(input int c);
    logic [2:0] one;
    one = 3'b001;
    return (c == 0) ? 3'b000 : (one << (c - 1));
  endfunction

  task automatic model_reset();
    m_col = 0; m_dwell = 0; m_code = 0; m_cnt = 0;
    m_fault = 0; m_done = 0; m_long_seen = 0;
  endtask

  task automatic model_step(input logic [2:0] l, input bit c);
    int s, code;
    bit cyc, legal;
    s = colour_of(l);
    code = 0;
    cyc = 0;
    if (s < 0) begin
      code = 1;
    end else if (s == m_col) begin
      if (DE && m_col != 0 && m_dwell == req_tab[m_col] && !m_long_seen) begin
        code = 4;
        m_long_seen = 1;
      end
      if (m_dwell < DMAX) m_dwell++;
    end else begin
      legal = (s == 0) || (s == (m_col % 3) + 1);
      if (!legal) code = 2;
      else if (DE && s != 0 && m_col != 0 && m_dwell < req_tab[m_col]) code = 3;
      cyc = legal && m_col == 3 && s == 1 && code == 0;
      m_col = s;
      m_dwell = 1;
      m_long_seen = 0;
    end
    m_done = cyc;
    if (cyc && m_cnt < 65535) m_cnt++;
    if (code != 0 && (!m_fault || c)) begin
      m_fault = 1; m_code = code;
    end else if (c) begin
      m_fault = 0; m_code = 0;
    end
    exp_q.push_back({m_fault, m_code[2:0], m_dwell[7:0], m_cnt[15:0], m_done, m_col[1:0]});
  endtask

  task automatic check_model();
    logic [30:0] e;
    e = exp_q.pop_front();
    chk("cyc fault",      fault,      e[30]);
    chk("cyc fault_code", fault_code, e[29:27]);
    chk("cyc cur_dwell",  cur_dwell,  e[26:19]);
    chk("cyc cycle_cnt",  cycle_cnt,  e[18:3]);
    chk("cyc cycle_done", cycle_done, e[2]);
    chk("cyc state",      dbg_state,  e[1:0]);
  endtask

  task automatic step(input logic [2:0] l, input bit c);
    light_in  = l;
    clr_fault = c;
    @(posedge clk);
    #1;
    clr_fault = 1'b0;
    model_step(l, c);
    check_model();
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " fault"},      fault,      0);
    chk({nm, " fault_code"}, fault_code, 0);
    chk({nm, " cur_dwell"},  cur_dwell,  0);
    chk({nm, " cycle_cnt"},  cycle_cnt,  0);
    chk({nm, " cycle_done"}, cycle_done, 0);
    chk({nm, " state"},      dbg_state,  0);
  endtask

  typedef struct {
    logic [2:0] light;
    int n;
    int clr;
    int e_fault;
    int e_code;
    int e_dwell;
    int e_cnt;
    int e_done;
    int e_state;
  } seg_t;

  localparam int NSEG = 29;
  seg_t segs[NSEG];

  initial begin
    logic [2:0] bad_enc[4];
    bad_enc = '{3'b011, 3'b101, 3'b110, 3'b111};

    segs[0]  = '{OFF,    5,  0, 0,       0,          5,  0, 0, 0};
    segs[1]  = '{RED,    31, 0, 0,       0,          31, 0, 0, 1};
    segs[2]  = '{YEL,    11, 0, 0,       0,          11, 0, 0, 2};
    segs[3]  = '{GRN,    41, 0, 0,       0,          41, 0, 0, 3};
    segs[4]  = '{RED,    1,  0, 0,       0,          1,  1, 1, 1};
    segs[5]  = '{RED,    19, 0, 0,       0,          20, 1, 0, 1};
    segs[6]  = '{YEL,    1,  0, int'(DE), DE ? 3 : 0, 1,  1, 0, 2};
    segs[7]  = '{YEL,    10, 1, 0,       0,          11, 1, 0, 2};
    segs[8]  = '{GRN,    41, 0, 0,       0,          41, 1, 0, 3};
    segs[9]  = '{RED,    1,  0, 0,       0,          1,  2, 1, 1};
    segs[10] = '{RED,    31, 0, int'(DE), DE ? 4 : 0, 32, 2, 0, 1};
    segs[11] = '{RED,    1,  1, 0,       0,          33, 2, 0, 1};
    segs[12] = '{RED,    2,  0, 0,       0,          35, 2, 0, 1};
    segs[13] = '{YEL,    5,  0, 0,       0,          5,  2, 0, 2};
    segs[14] = '{3'b011, 1,  0, 1,       1,          5,  2, 0, 2};
    segs[15] = '{RED,    3,  0, 1,       1,          3,  2, 0, 1};
    segs[16] = '{GRN,    1,  0, 1,       1,          1,  2, 0, 3};
    segs[17] = '{OFF,    1,  1, 0,       0,          1,  2, 0, 0};
    segs[18] = '{RED,    2,  0, 0,       0,          2,  2, 0, 1};
    segs[19] = '{GRN,    1,  0, 1,       2,          1,  2, 0, 3};
    segs[20] = '{GRN,    9,  1, 0,       0,          10, 2, 0, 3};
    segs[21] = '{OFF,    1,  0, 0,       0,          1,  2, 0, 0};
    segs[22] = '{YEL,    1,  0, 1,       2,          1,  2, 0, 2};
    segs[23] = '{YEL,    10, 0, 1,       2,          11, 2, 0, 2};
    segs[24] = '{GRN,    41, 0, 1,       2,          41, 2, 0, 3};
    segs[25] = '{RED,    1,  0, 1,       2,          1,  3, 1, 1};
    segs[26] = '{RED,    30, 0, 1,       2,          31, 3, 0, 1};
    segs[27] = '{YEL,    11, 0, 1,       2,          11, 3, 0, 2};
    segs[28] = '{GRN,    5,  0, 1,       2,          5,  3, 0, 3};

    // Clock/reset
    model_reset();
    #2;
    chk_reset_vals("reset");
    #6;
    rst = 1'b1;

    for (int i = 0; i < NSEG; i++) begin
      for (int k = 0; k < segs[i].n; k++) step(segs[i].light, (segs[i].clr != 0) && (k == 0));
      chk($sformatf("seg%0d fault", i),      fault,      segs[i].e_fault);
      chk($sformatf("seg%0d fault_code", i), fault_code, segs[i].e_code);
      chk($sformatf("seg%0d cur_dwell", i),  cur_dwell,  segs[i].e_dwell);
      chk($sformatf("seg%0d cycle_cnt", i),  cycle_cnt,  segs[i].e_cnt);
      chk($sformatf("seg%0d cycle_done", i), cycle_done, segs[i].e_done);
      chk($sformatf("seg%0d state", i),      dbg_state,  segs[i].e_state);
    end

    // Asynchronous reset mid-GREEN with faults and counted cycles outstanding.
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("async_rst");
    light_in = RED;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    step(RED, 1'b0);
    chk("post_rst red fault", fault, 0);
    chk("post_rst red dwell", cur_dwell, 1);
    chk("post_rst red state", dbg_state, 1);

    // After reset the first non-OFF colour must be RED.
    #2;
    rst = 1'b0;
    #2;
    model_reset();
    rst = 1'b1;
    step(OFF, 1'b0);
    step(OFF, 1'b0);
    step(GRN, 1'b0);
    chk("post_rst grn code", fault_code, 2);
    chk("post_rst grn state", dbg_state, 3);

    // OFF has no limit; the dwell counter saturates.
    step(OFF, 1'b1);
    for (int k = 0; k < 299; k++) step(OFF, 1'b0);
    chk("off saturate dwell", cur_dwell, DMAX);
    chk("off saturate fault", fault, 0);

    // Randomised runs, mostly legal order with lengths around the required dwell.
    step(OFF, 1'b1);
    for (int r = 0; r < 70; r++) begin
      int pick, len, c;
      logic [2:0] l;
      pick = $urandom_range(0, 99);
      if (pick < 70) begin
        c = (m_col % 3) + 1;
        l = light_of(c);
        len = req_tab[c] + $urandom_range(0, 6) - 3;
      end else if (pick < 78) begin
        l = OFF;
        len = $urandom_range(1, 4);
      end else if (pick < 86) begin
        l = bad_enc[$urandom_range(0, 3)];
        len = $urandom_range(1, 2);
      end else begin
        c = $urandom_range(1, 3);
        l = light_of(c);
        len = $urandom_range(1, 45);
      end
      for (int k = 0; k < len; k++) step(l, $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
